// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The optional misaligned-redirect check is enabled with IFETCH_MISALIGN_CHK_EN.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ifetch_entry_t;

endpackage

// File: rtl/ifetch_unit_if.sv
// Memory request/response and decode-side signals of the fetch stage.
// exc_misaligned_o exists only when IFETCH_MISALIGN_CHK_EN is defined.
interface ifetch_unit_if;
  // Handshakes: a request transfers on a cycle with imem_req_o & imem_gnt_i; one
  // response per grant returns in order on imem_rvalid_i (no back-pressure); an
  // instruction transfers to decode on a cycle with valid_o & ready_i.
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
`ifdef IFETCH_MISALIGN_CHK_EN
  logic        exc_misaligned_o;

  modport master (
    output imem_req_o, imem_addr_o, valid_o, instr_o, pc_o, exc_misaligned_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, ready_i
  );
  modport slave (
    input  imem_req_o, imem_addr_o, valid_o, instr_o, pc_o, exc_misaligned_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, ready_i
  );
`else
  modport master (
    output imem_req_o, imem_addr_o, valid_o, instr_o, pc_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, ready_i
  );
  modport slave (
    input  imem_req_o, imem_addr_o, valid_o, instr_o, pc_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, ready_i
  );
`endif
endinterface

// File: rtl/ifetch_unit_fifo.sv
// Small in-order FIFO with flush; DEPTH must be a power of two.
// Used both for fetched instructions and for the in-flight PC queue.
module ifetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;

  assign do_pop = pop & (count != '0);
  assign rdata  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  // Pushing into a full FIFO is only legal when the head leaves in the same cycle.
  assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && !do_pop && count == CW'(DEPTH)));

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC, credit-limited memory requests, redirect discard.
// Define IFETCH_MISALIGN_CHK_EN to halt on misaligned redirect targets.
module ifetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input logic           clk,
  input logic           rst,
  ifetch_unit_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = CW + 1;

  fetch_state_t  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] fifo_count, pcq_count;
  logic [SW-1:0] credit_used;
  logic          req, grant, rsp, redirect, accept, valid, misaligned;
  logic [31:0]   target_pc, rsp_pc;
  ifetch_entry_t push_entry, head_entry;

  assign redirect    = bus.redirect_i;
  assign rsp         = bus.imem_rvalid_i;
  assign grant       = req & bus.imem_gnt_i;
  assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count};

`ifdef IFETCH_MISALIGN_CHK_EN
  assign target_pc            = bus.redirect_pc_i;
  assign misaligned           = (bus.redirect_pc_i[1:0] != 2'b00);
  assign bus.exc_misaligned_o = (state_q == S_HALT);
`else
  assign target_pc  = bus.redirect_pc_i & 32'hFFFF_FFFC;
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_BOOT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    case (state_q)
      S_BOOT:  state_d = S_FETCH;
      S_FETCH: req = ~redirect & (credit_used < SW'(FIFO_DEPTH));
      S_HALT:  state_d = S_HALT;
      default: state_d = S_BOOT;
    endcase
    if (redirect) state_d = misaligned ? S_HALT : S_FETCH;
  end

  // Every in-flight response at redirect time (including this cycle's grant) is stale.
  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q + CW'(grant) - CW'(rsp);
    discard_d     = discard_q;
    if (redirect)    pc_d = target_pc;
    else if (grant)  pc_d = pc_q + 32'd4;
    if (redirect)                      discard_d = outstanding_d;
    else if (rsp && discard_q != '0)   discard_d = discard_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  assign accept     = rsp & ~redirect & (discard_q == '0);
  assign push_entry = '{instr: bus.imem_rdata_i, pc: rsp_pc};
  assign valid      = (fifo_count != '0) & (state_q != S_HALT);

  ifetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_pc_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (grant),
    .pop   (rsp),
    .flush (1'b0),
    .wdata (pc_q),
    .rdata (rsp_pc),
    .count (pcq_count)
  );

  ifetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(ifetch_entry_t))) u_instr_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (valid & bus.ready_i),
    .flush (redirect),
    .wdata (push_entry),
    .rdata (head_entry),
    .count (fifo_count)
  );

  assert property (@(posedge clk) disable iff (rst) pcq_count == outstanding_q);

  assign bus.imem_req_o  = req;
  assign bus.imem_addr_o = pc_q;
  assign bus.valid_o     = valid;
  assign bus.instr_o     = valid ? head_entry.instr : NOP_INSTR;
  assign bus.pc_o        = valid ? head_entry.pc : 32'h0;

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized bench for ifetch_unit against a transaction-level fetch model.
// Build with IFETCH_MISALIGN_CHK_EN to cover the misaligned-halt behaviour.
module tb_ifetch_unit;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          FIFO_DEPTH = 2;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] pc;
    int          epoch;
    int          due;
  } mem_req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ifetch_unit_if bus ();

  ifetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model state
  mem_req_t    pending[$];
  logic [63:0] exp_q[$];
  logic [31:0] model_pc;
  int          epoch = 0;
  int          cyc = 0;
  bit          boot;
  bit          halted;

  // Stimulus knobs
  int gnt_pct = 100, rdy_pct = 100, rsp_pct = 100, redir_permille = 0;
  int lat_min = 1, lat_max = 1;
  bit force_redir = 0, redir_on_rsp = 0;
  logic [31:0] force_pc = 32'h0;

  int tests = 0;
  int fails = 0;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic drive_idle();
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = 32'h0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    bus.ready_i       = 1'b0;
  endtask

  // Called at posedge+1; asserts reset asynchronously and checks outputs immediately.
  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    #1;
    check_eq("rst_req", bus.imem_req_o, 1'b0);
    check_eq("rst_addr", bus.imem_addr_o, RESET_PC);
    check_eq("rst_valid", bus.valid_o, 1'b0);
    check_eq("rst_instr", bus.instr_o, NOP);
    check_eq("rst_pc", bus.pc_o, 32'h0);
`ifdef IFETCH_MISALIGN_CHK_EN
    check_eq("rst_exc", bus.exc_misaligned_o, 1'b0);
`endif
    pending.delete();
    exp_q.delete();
    model_pc = RESET_PC;
    boot     = 1'b1;
    halted   = 1'b0;
    epoch++;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One clock cycle: drive inputs, check outputs, then advance the model at the edge.
  task automatic step();
    bit          rsp, redir, gnt, hs, exp_req;
    logic [31:0] rpc, addr_s;
    mem_req_t    e;
    rsp = (pending.size() != 0) && (pending[0].due <= cyc) && ($urandom_range(1, 100) <= rsp_pct);
    redir = force_redir || (redir_on_rsp && rsp) || ($urandom_range(1, 1000) <= redir_permille);
    if (redir_on_rsp && rsp) redir_on_rsp = 1'b0;
    rpc = force_redir ? force_pc :
          (($urandom & 32'h0000_0FFC) | (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'h0));
    bus.imem_rvalid_i = rsp;
    bus.imem_rdata_i  = rsp ? mem_word(pending[0].addr) : $urandom;
    bus.redirect_i    = redir;
    bus.redirect_pc_i = rpc;
    bus.ready_i       = ($urandom_range(1, 100) <= rdy_pct);
    bus.imem_gnt_i    = 1'b0;
    #1;
    exp_req = !boot && !halted && !redir && ((pending.size() + exp_q.size()) < FIFO_DEPTH);
    check_eq("req", bus.imem_req_o, exp_req);
    if (exp_req) check_eq("addr", bus.imem_addr_o, model_pc);
    check_eq("valid", bus.valid_o, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check_eq("instr", bus.instr_o, exp_q[0][63:32]);
      check_eq("pc", bus.pc_o, exp_q[0][31:0]);
    end else begin
      check_eq("nop", bus.instr_o, NOP);
    end
`ifdef IFETCH_MISALIGN_CHK_EN
    check_eq("exc", bus.exc_misaligned_o, halted);
`endif
    gnt    = bus.imem_req_o && ($urandom_range(1, 100) <= gnt_pct);
    addr_s = bus.imem_addr_o;
    hs     = (exp_q.size() != 0) && bus.ready_i;
    bus.imem_gnt_i = gnt;
    @(posedge clk);
    #1;
    if (hs) void'(exp_q.pop_front());
    if (rsp) begin
      e = pending.pop_front();
      if (!redir && e.epoch == epoch) exp_q.push_back({mem_word(e.pc), e.pc});
    end
    if (gnt) begin
      pending.push_back('{addr: addr_s, pc: model_pc, epoch: epoch,
                          due: cyc + $urandom_range(lat_min, lat_max)});
      model_pc = model_pc + 32'd4;
    end
    if (redir) begin
      exp_q.delete();
      epoch++;
`ifdef IFETCH_MISALIGN_CHK_EN
      halted   = (rpc[1:0] != 2'b00);
      model_pc = rpc;
`else
      model_pc = {rpc[31:2], 2'b00};
`endif
    end
    boot = 1'b0;
    cyc++;
  endtask

  task automatic redirect_to(logic [31:0] pc);
    force_redir = 1'b1;
    force_pc    = pc;
    step();
    force_redir = 1'b0;
  endtask

  initial begin
    drive_idle();
    @(posedge clk);
    #1;
    do_reset();

    // Zero-wait memory, decoder always ready
    repeat (20) step();

    // Decoder stalls for 10 cycles, then drains
    rdy_pct = 0;
    repeat (10) step();
    rdy_pct = 100;
    repeat (10) step();

    // Latency 3, redirect with two requests in flight
    lat_min = 3;
    lat_max = 3;
    for (int i = 0; i < 20 && pending.size() != 2; i++) step();
    check_eq("inflight2", pending.size(), 2);
    redirect_to(32'h0000_0100);
    for (int i = 0; i < 30 && !bus.valid_o; i++) step();
    check_eq("redir_valid", bus.valid_o, 1'b1);
    check_eq("redir_first_pc", bus.pc_o, 32'h0000_0100);
    repeat (10) step();

    // Redirect coinciding with a returning response
    lat_min = 1;
    lat_max = 2;
    redir_on_rsp = 1'b1;
    force_pc = 32'h0000_0040;
    for (int i = 0; i < 20 && redir_on_rsp; i++) step();
    repeat (10) step();

    // Misaligned redirect, then an aligned one
    redirect_to(32'h0000_0102);
    repeat (6) step();
    redirect_to(32'h0000_0200);
    for (int i = 0; i < 30 && !bus.valid_o; i++) step();
    check_eq("post_halt_pc", bus.pc_o, 32'h0000_0200);
    repeat (5) step();

    // Address wrap at the top of the address space
    redirect_to(32'hFFFF_FFF8);
    repeat (12) step();

    // Random traffic
    gnt_pct = 70;
    rdy_pct = 60;
    rsp_pct = 80;
    lat_min = 1;
    lat_max = 4;
    redir_permille = 30;
    repeat (1500) step();

    // Reset in the middle of traffic, then more random traffic
    do_reset();
    repeat (300) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
